operand_loader: RTL and testbench

Upstream stage feeding the 8-bit adder/display block on DE2-115. Debounces two push-buttons, latches operand A and then operand B from an 8-bit switch bus, and presents both to the downstream adder with a valid/ready handshake. It replaces raw switch wiring, so the adder sees stable operands that change only on deliberate key presses.

---
 rtl/operand_loader_pkg.sv | 21 ++
 rtl/operand_loader_key_debounce.sv | 60 ++++++
 rtl/operand_loader.sv | 160 ++++++++++++++++
 tb/tb_operand_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: stage encoding and default sizing.
// Optional clear key is enabled by defining OPERAND_LOADER_CLEAR_EN.
package operand_loader_pkg;

    typedef enum logic [1:0] {
        STAGE_EMPTY  = 2'd0,
        STAGE_HAVE_A = 2'd1,
        STAGE_FULL   = 2'd2,
        STAGE_SENT   = 2'd3
    } stage_t;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_WIDTH           = 8;

    // Counter width that still works when no debouncing is requested (cycles == 1).
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/operand_loader_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// strobe on the debounced press (1->0) edge. Release never produces a strobe.
module key_debounce
    import operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          level_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_next;
    logic          changed;

    assign changed = (sync != level_q);

    // Count consecutive cycles at the same synchronized level, saturating at the limit.
    always_comb begin
        cnt_next = cnt_q;
        if (changed) begin
            cnt_next = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_next = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b1;
            sync    <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            deb_q   <= 1'b1;
            deb_d   <= 1'b1;
            press   <= 1'b0;
        end else begin
            meta    <= key_n;
            sync    <= meta;
            level_q <= sync;
            cnt_q   <= cnt_next;
            if (cnt_next == CNT_MAX) begin
                deb_q <= sync;
            end
            deb_d   <= deb_q;
            press   <= deb_d & ~deb_q;
        end
    end

endmodule

// File: rtl/operand_loader.sv
// Debounced two-key operand loader feeding the adder with a valid/ready pair.
// Define OPERAND_LOADER_CLEAR_EN to add the key_clear_n input (returns to EMPTY).
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int WIDTH           = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef OPERAND_LOADER_CLEAR_EN
    input  logic             key_clear_n,
`endif
    input  logic             key_load_n,
    input  logic             key_send_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       stage
);

    // Handshake: op_valid rises only with a complete pair, then op_valid, op_a and
    // op_b stay constant until a cycle with op_valid && op_ready, which is the transfer.

    logic [1:0]       rst_pipe;
    logic             rst_sync_n;
    logic [WIDTH-1:0] sw_meta;
    logic [WIDTH-1:0] sw_sync;
    logic             load_strobe;
    logic             send_strobe;
    logic             clear_strobe;
    stage_t           state_q;
    stage_t           state_next;
    logic             valid_q;
    logic             xfer;
    logic             load_a_en;
    logic             load_b_en;
    logic             clear_en;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;

    // Asynchronous assertion, release synchronized to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_pipe[1];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_key (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .key_n (key_load_n),
        .press (load_strobe)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_send_key (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .key_n (key_send_n),
        .press (send_strobe)
    );

`ifdef OPERAND_LOADER_CLEAR_EN
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .key_n (key_clear_n),
        .press (clear_strobe)
    );
`else
    assign clear_strobe = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    assign xfer = valid_q & op_ready;

    // State register; op_valid is registered alongside so it is exactly "state is FULL".
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= STAGE_EMPTY;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_next;
            valid_q <= (state_next == STAGE_FULL);
        end
    end

    // Next state: clear beats everything, load beats send, FULL only leaves on transfer.
    always_comb begin
        state_next = state_q;
        if (clear_strobe) begin
            state_next = STAGE_EMPTY;
        end else begin
            case (state_q)
                STAGE_EMPTY: begin
                    if (load_strobe) state_next = STAGE_HAVE_A;
                end
                STAGE_HAVE_A: begin
                    if (load_strobe) state_next = STAGE_FULL;
                end
                STAGE_FULL: begin
                    if (xfer) state_next = STAGE_SENT;
                end
                STAGE_SENT: begin
                    if (load_strobe) begin
                        state_next = STAGE_HAVE_A;
                    end else if (send_strobe) begin
                        state_next = STAGE_FULL;
                    end
                end
                default: state_next = STAGE_EMPTY;
            endcase
        end
    end

    // Operand register enables decoded from the current state and strobes.
    always_comb begin
        load_a_en = 1'b0;
        load_b_en = 1'b0;
        clear_en  = clear_strobe;
        if (!clear_strobe && load_strobe) begin
            load_a_en = (state_q == STAGE_EMPTY) || (state_q == STAGE_SENT);
            load_b_en = (state_q == STAGE_HAVE_A);
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (clear_en) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else begin
            if (load_a_en) op_a_q <= sw_sync;
            if (load_b_en) op_b_q <= sw_sync;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_valid = valid_q;
    assign stage    = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader with a short debounce window.
// Exercises the clear key when OPERAND_LOADER_CLEAR_EN is defined.
module tb_operand_loader;

    localparam int DEB = 4;
    localparam int W   = 8;

    logic         clk;
    logic         rst_n;
    logic         key_load_n;
    logic         key_send_n;
`ifdef OPERAND_LOADER_CLEAR_EN
    logic         key_clear_n;
`endif
    logic [W-1:0] sw;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_valid;
    logic         op_ready;
    logic [1:0]   stage;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    logic [2*W-1:0] exp_q[$];

    operand_loader #(.DEBOUNCE_CYCLES(DEB), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef OPERAND_LOADER_CLEAR_EN
        .key_clear_n(key_clear_n),
`endif
        .key_load_n (key_load_n),
        .key_send_n (key_send_n),
        .sw         (sw),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .stage      (stage)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: key_load_n = v;
            1: key_send_n = v;
`ifdef OPERAND_LOADER_CLEAR_EN
            2: key_clear_n = v;
`endif
            default: ;
        endcase
    endtask

    task automatic press(input int k, input int hold);
        set_key(k, 1'b0);
        tick(hold);
        set_key(k, 1'b1);
        tick(DEB + 8);
    endtask

    task automatic expect_state(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic v, input logic [1:0] s);
        check({tag, "_op_a"}, 32'(op_a), 32'(a));
        check({tag, "_op_b"}, 32'(op_b), 32'(b));
        check({tag, "_valid"}, 32'(op_valid), 32'(v));
        check({tag, "_stage"}, 32'(stage), 32'(s));
    endtask

    task automatic async_reset_assert();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
    endtask

    // Scoreboard: every accepted pair must match the head of the expected queue.
    always @(negedge clk) begin
        if (op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                check("xfer_pair", 32'({op_a, op_b}), 32'(exp_q.pop_front()));
                xfers++;
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        key_load_n = 1'b1;
        key_send_n = 1'b1;
`ifdef OPERAND_LOADER_CLEAR_EN
        key_clear_n = 1'b1;
`endif
        sw         = 8'h00;
        op_ready   = 1'b0;
        tick(3);
        expect_state("reset", 8'h00, 8'h00, 1'b0, 2'd0);
        rst_n = 1'b1;
        tick(4);

        // First load, with strobe latency: state moves on the (DEB+4)th edge after the press.
        sw = 8'h3C;
        set_key(0, 1'b0);
        tick(DEB + 3);
        check("latency_early_stage", 32'(stage), 32'd0);
        tick(1);
        check("latency_hit_stage", 32'(stage), 32'd1);
        check("latency_hit_op_a", 32'(op_a), 32'h3C);
        set_key(0, 1'b1);
        tick(DEB + 8);

        // Second load with a press exactly DEB cycles long.
        sw = 8'hA5;
        exp_q.push_back({8'h3C, 8'hA5});
        press(0, DEB);
        expect_state("full", 8'h3C, 8'hA5, 1'b1, 2'd2);

        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        expect_state("sent", 8'h3C, 8'hA5, 1'b0, 2'd3);

        // Reload A from SENT keeps old B; send in HAVE_A is ignored.
        sw = 8'h11;
        press(0, 6);
        expect_state("reload_a", 8'h11, 8'hA5, 1'b0, 2'd1);
        press(1, 6);
        expect_state("send_in_have_a", 8'h11, 8'hA5, 1'b0, 2'd1);

        sw = 8'h22;
        exp_q.push_back({8'h11, 8'h22});
        press(0, 5);
        tick(20);
        expect_state("full_wait", 8'h11, 8'h22, 1'b1, 2'd2);

        // Load and send while FULL must not disturb the pair.
        sw = 8'hFF;
        press(0, 6);
        press(1, 6);
        expect_state("full_ignore", 8'h11, 8'h22, 1'b1, 2'd2);

        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        check("sent2_stage", 32'(stage), 32'd3);

        // Resend the same pair.
        exp_q.push_back({8'h11, 8'h22});
        press(1, 6);
        expect_state("resend", 8'h11, 8'h22, 1'b1, 2'd2);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;

        // Load and send together from SENT: load wins; long hold gives no repeat.
        sw = 8'h5A;
        key_load_n = 1'b0;
        key_send_n = 1'b0;
        tick(40);
        key_load_n = 1'b1;
        key_send_n = 1'b1;
        tick(DEB + 8);
        expect_state("both_keys", 8'h5A, 8'h22, 1'b0, 2'd1);

        // Async reset while op_valid is high.
        sw = 8'h77;
        exp_q.push_back({8'h5A, 8'h77});
        press(0, 6);
        check("pre_reset_valid", 32'(op_valid), 32'd1);
        async_reset_assert();
        expect_state("async_rst_valid", 8'h00, 8'h00, 1'b0, 2'd0);
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(4);

        // Async reset in the middle of a debounce; key released during reset.
        sw = 8'h44;
        set_key(0, 1'b0);
        tick(2);
        async_reset_assert();
        check("async_rst_debounce_stage", 32'(stage), 32'd0);
        set_key(0, 1'b1);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        expect_state("no_spurious", 8'h00, 8'h00, 1'b0, 2'd0);

        // Bounce shorter than the window gives nothing; a full-window press gives one strobe.
        sw = 8'h99;
        for (int i = 0; i < 4; i++) begin
            set_key(0, 1'b0);
            tick(DEB - 1);
            set_key(0, 1'b1);
            tick(DEB - 1);
        end
        tick(DEB + 8);
        check("bounce_stage", 32'(stage), 32'd0);
        press(0, DEB);
        expect_state("single_strobe", 8'h99, 8'h00, 1'b0, 2'd1);

`ifdef OPERAND_LOADER_CLEAR_EN
        // Clear strobe in the same cycle as a handshake.
        sw = 8'h66;
        exp_q.push_back({8'h99, 8'h66});
        press(0, 6);
        check("pre_clear_valid", 32'(op_valid), 32'd1);
        set_key(2, 1'b0);
        tick(DEB + 3);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        expect_state("clear_vs_xfer", 8'h00, 8'h00, 1'b0, 2'd0);
        set_key(2, 1'b1);
        tick(DEB + 8);
`endif

        tick(4);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
